// File: rtl/anim_pkg.sv
// anim_pkg: shared state/wrap types and default per-state timing for anim_seq_fsm
package anim_pkg;
  typedef enum logic [2:0] {
    ST_STAND,
    ST_ATTACK,
    ST_MOVE_L,
    ST_MOVE_R,
    ST_HURT,
    ST_DEFEND,
    ST_DIE
  } anim_state_t;
  typedef enum logic [1:0] {
    WR_LOOP,
    WR_STOP,
    WR_HOLD
  } wrap_mode_t;
  localparam int DEF_LAST_STAND  = 7;
  localparam int DEF_LAST_MOVE_R = 3;
  localparam int DEF_LAST_MOVE_L = 4;
  localparam int DEF_LAST_ATTACK = 8;
  localparam int DEF_LAST_HURT   = 3;
  localparam int DEF_LAST_DEFEND = 0;
  localparam int DEF_LAST_DIE    = 11;
  localparam int DEF_DLY_STAND   = 8;
  localparam int DEF_DLY_MOVE    = 8;
  localparam int DEF_DLY_ATTACK  = 2;
  localparam int DEF_DLY_HURT    = 3;
  localparam int DEF_DLY_DEFEND  = 2;
  localparam int DEF_DLY_DIE     = 3;
  localparam int DEF_HIT_FRAME   = 5;
endpackage

// File: rtl/anim_frame_ctr.sv
// anim_frame_ctr: per-frame tick divider and frame index with loop/stop/hold wrap
module anim_frame_ctr
  import anim_pkg::*;
#(
  parameter int FRAME_W = 8,
  parameter int DELAY_W = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_clear,
  input  logic               i_advance,
  input  logic [FRAME_W-1:0] i_last,
  input  logic [DELAY_W-1:0] i_dly,
  input  wrap_mode_t         i_wrap_mode,
  output logic [FRAME_W-1:0] o_frame,
  output logic               o_step,
  output logic               o_at_end
);
  logic [DELAY_W-1:0] r_delay;
  logic [FRAME_W-1:0] r_frame;
  assign o_frame  = r_frame;
  assign o_step   = r_delay >= i_dly;
  assign o_at_end = o_step && r_frame >= i_last;
  // count ticks within a frame, then step the frame; at the last frame wrap or hold
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_delay <= '0;
      r_frame <= '0;
    end else if (i_clear) begin
      r_delay <= '0;
      r_frame <= '0;
    end else if (i_advance) begin
      r_delay <= o_step ? '0 : r_delay + 1'b1;
      if (o_step)
        r_frame <= !o_at_end ? r_frame + 1'b1 : i_wrap_mode == WR_HOLD ? r_frame : '0;
    end
endmodule

// File: rtl/anim_seq_fsm.sv
// anim_seq_fsm: character animation sequencer; optional ANIM_FACING_EN adds facing_o
module anim_seq_fsm
  import anim_pkg::*;
#(
  parameter int FRAME_W     = 8,
  parameter int DELAY_W     = 8,
  parameter int LAST_STAND  = DEF_LAST_STAND,
  parameter int LAST_MOVE_R = DEF_LAST_MOVE_R,
  parameter int LAST_MOVE_L = DEF_LAST_MOVE_L,
  parameter int LAST_ATTACK = DEF_LAST_ATTACK,
  parameter int LAST_HURT   = DEF_LAST_HURT,
  parameter int LAST_DEFEND = DEF_LAST_DEFEND,
  parameter int LAST_DIE    = DEF_LAST_DIE,
  parameter int DLY_STAND   = DEF_DLY_STAND,
  parameter int DLY_MOVE    = DEF_DLY_MOVE,
  parameter int DLY_ATTACK  = DEF_DLY_ATTACK,
  parameter int DLY_HURT    = DEF_DLY_HURT,
  parameter int DLY_DEFEND  = DEF_DLY_DEFEND,
  parameter int DLY_DIE     = DEF_DLY_DIE,
  parameter int HIT_FRAME   = DEF_HIT_FRAME
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               frame_clk,
  input  logic               game_active,
  input  logic               exist_i,
  input  logic               attack_i,
  input  logic               hurt_i,
  input  logic               defend_i,
  input  logic               move_r_i,
  input  logic               move_l_i,
  input  logic               die_i,
  output logic [2:0]         state_o,
  output logic [FRAME_W-1:0] frame_o,
  output logic               move_r_o,
  output logic               move_l_o,
  output logic               anim_done_o,
  output logic               hit_o,
  output logic               dead_o
`ifdef ANIM_FACING_EN
  ,
  output logic               facing_o
`endif
);
  localparam logic [FRAME_W-1:0] L_HIT_PREV = FRAME_W'(HIT_FRAME - 1);
  anim_state_t        r_state;
  logic               r_fclk_q;
  logic               r_tick;
  logic               r_ga_q;
  logic               r_restart;
  logic               r_move_r;
  logic               r_move_l;
  logic               r_done;
  logic               r_hit;
  anim_state_t        w_nxt;
  anim_state_t        w_req;
  logic               w_any;
  logic               w_intr;
  logic               w_upd;
  logic               w_adv;
  logic               w_mr;
  logic               w_ml;
  logic               w_done;
  logic               w_hit;
  logic               w_clear;
  logic               w_advance;
  logic               w_step;
  logic               w_at_end;
  logic [FRAME_W-1:0] w_frame;
  logic [FRAME_W-1:0] w_last;
  logic [DELAY_W-1:0] w_dly;
  wrap_mode_t         w_wrap;
  assign w_upd  = r_tick & exist_i & ~r_restart;
  assign w_any  = die_i | hurt_i | attack_i | defend_i | move_r_i | move_l_i;
  assign w_intr = die_i | hurt_i | attack_i;
  assign w_req  = die_i ? ST_DIE : hurt_i ? ST_HURT : attack_i ? ST_ATTACK :
                  defend_i ? ST_DEFEND : move_r_i ? ST_MOVE_R : ST_MOVE_L;
  assign w_last = r_state == ST_STAND  ? FRAME_W'(LAST_STAND)  :
                  r_state == ST_MOVE_R ? FRAME_W'(LAST_MOVE_R) :
                  r_state == ST_MOVE_L ? FRAME_W'(LAST_MOVE_L) :
                  r_state == ST_ATTACK ? FRAME_W'(LAST_ATTACK) :
                  r_state == ST_HURT   ? FRAME_W'(LAST_HURT)   :
                  r_state == ST_DEFEND ? FRAME_W'(LAST_DEFEND) : FRAME_W'(LAST_DIE);
  assign w_dly  = r_state == ST_STAND  ? DELAY_W'(DLY_STAND)  :
                  r_state == ST_MOVE_R || r_state == ST_MOVE_L ? DELAY_W'(DLY_MOVE) :
                  r_state == ST_ATTACK ? DELAY_W'(DLY_ATTACK) :
                  r_state == ST_HURT   ? DELAY_W'(DLY_HURT)   :
                  r_state == ST_DEFEND ? DELAY_W'(DLY_DEFEND) : DELAY_W'(DLY_DIE);
  assign w_wrap = r_state == ST_DIE ? WR_HOLD :
                  r_state == ST_ATTACK || r_state == ST_HURT ? WR_STOP : WR_LOOP;
  // any change of state restarts the frame counter; staying just advances it
  assign w_clear   = r_restart | (w_upd & (w_nxt != r_state));
  assign w_advance = w_upd & w_adv;
  // hit strobes when the attack frame becomes HIT_FRAME, including entry when it is frame 0
  assign w_hit = w_upd && w_nxt == ST_ATTACK &&
                 (r_state == ST_ATTACK ? w_step && w_frame == L_HIT_PREV : HIT_FRAME == 0);
  // next-state selection with per-state interrupt rules
  always_comb begin
    w_nxt  = r_state;
    w_adv  = 1'b0;
    w_mr   = 1'b0;
    w_ml   = 1'b0;
    w_done = 1'b0;
    case (r_state)
      ST_STAND: begin
        w_nxt = w_any ? w_req : ST_STAND;
        w_adv = ~w_any;
      end
      ST_MOVE_R: begin
        w_nxt = w_intr ? w_req : move_r_i ? ST_MOVE_R : move_l_i ? ST_MOVE_L : ST_STAND;
        w_adv = ~w_intr & move_r_i;
        w_mr  = ~w_intr & move_r_i;
      end
      ST_MOVE_L: begin
        w_nxt = w_intr ? w_req : move_l_i ? ST_MOVE_L : move_r_i ? ST_MOVE_R : ST_STAND;
        w_adv = ~w_intr & move_l_i;
        w_ml  = ~w_intr & move_l_i;
      end
      ST_ATTACK, ST_HURT: begin
        w_nxt  = die_i ? ST_DIE : w_at_end ? ST_STAND : r_state;
        w_adv  = ~die_i & ~w_at_end;
        w_done = ~die_i & w_at_end;
      end
      ST_DEFEND: begin
        w_nxt = die_i ? ST_DIE : w_at_end && !defend_i ? ST_STAND : ST_DEFEND;
        w_adv = ~die_i & (~w_at_end | defend_i);
      end
      default: w_adv = 1'b1;
    endcase
  end
  // edge detectors for the frame tick and the game restart
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      r_fclk_q  <= 1'b0;
      r_tick    <= 1'b0;
      r_ga_q    <= 1'b0;
      r_restart <= 1'b0;
    end else begin
      r_fclk_q  <= frame_clk;
      r_tick    <= frame_clk & ~r_fclk_q;
      r_ga_q    <= game_active;
      r_restart <= game_active & ~r_ga_q;
    end
  // state register and one-cycle strobes, only on qualified tick cycles
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      r_state  <= ST_STAND;
      r_move_r <= 1'b0;
      r_move_l <= 1'b0;
      r_done   <= 1'b0;
      r_hit    <= 1'b0;
    end else begin
      r_state  <= r_restart ? ST_STAND : w_upd ? w_nxt : r_state;
      r_move_r <= w_upd & w_mr;
      r_move_l <= w_upd & w_ml;
      r_done   <= w_upd & w_done;
      r_hit    <= w_hit;
    end
  anim_frame_ctr #(
    .FRAME_W(FRAME_W),
    .DELAY_W(DELAY_W)
  ) u_ctr (
    .i_clk      (Clk),
    .i_rst_n    (Reset_n),
    .i_clear    (w_clear),
    .i_advance  (w_advance),
    .i_last     (w_last),
    .i_dly      (w_dly),
    .i_wrap_mode(w_wrap),
    .o_frame    (w_frame),
    .o_step     (w_step),
    .o_at_end   (w_at_end)
  );
  assign state_o     = r_state;
  assign frame_o     = w_frame;
  assign move_r_o    = r_move_r;
  assign move_l_o    = r_move_l;
  assign anim_done_o = r_done;
  assign hit_o       = r_hit;
  assign dead_o      = r_state == ST_DIE && w_frame == FRAME_W'(LAST_DIE);
`ifdef ANIM_FACING_EN
  logic r_facing;
  // facing follows the last movement direction entered
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) r_facing <= 1'b0;
    else if (w_upd && w_nxt != r_state)
      r_facing <= w_nxt == ST_MOVE_L ? 1'b1 : w_nxt == ST_MOVE_R ? 1'b0 : r_facing;
  assign facing_o = r_facing;
`endif
endmodule
